// File: rtl/mac_window_unit.sv
// Streaming signed 8x8 multiply-accumulate over K-element windows with per-window bias,
// followed by round/shift/saturate/ReLU requantization to a signed 8-bit result.
module mac_window_unit #(
  parameter int unsigned K     = 4,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned SHIFT = 4,
  parameter bit          RELU  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        in_valid,
  input  logic [7:0]  act,
  input  logic [7:0]  weight,
  input  logic [15:0] bias,
  output logic [7:0]  layer2,
  output logic        out_valid,
  output logic        busy
);

  localparam int unsigned CNT_W  = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(K - 1);
  localparam logic signed [ACC_W-1:0] RND      = (SHIFT > 0) ? (ACC_W'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ACC_W'(-128);

  logic                    accept;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    s_valid_q, s_valid_d, s_first_q, s_first_d, s_last_q, s_last_d;
  logic signed [7:0]       s_act_q, s_act_d, s_wt_q, s_wt_d;
  logic signed [15:0]      s_bias_q, s_bias_d;

  logic                    p_valid_q, p_valid_d, p_first_q, p_first_d, p_last_q, p_last_d;
  logic signed [15:0]      p_prod_q, p_prod_d, p_bias_q, p_bias_d;

  logic                    a_valid_q, a_valid_d, a_last_q, a_last_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  logic                    q_valid_q, q_valid_d;
  logic signed [7:0]       layer2_q, layer2_d;

  logic signed [ACC_W-1:0] rnd_sum, shifted;
  logic signed [7:0]       sat8;

  assign accept = in_valid & enable;

  // Requantize the finished accumulator: round half up, floor shift, saturate, optional ReLU.
  always_comb begin
    rnd_sum = acc_q + RND;
    shifted = rnd_sum >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat8 = 8'sd127;
    end else if (shifted < SAT_MIN) begin
      sat8 = 8'sh80;
    end else begin
      sat8 = 8'(shifted);
    end
    if (RELU && sat8[7]) begin
      sat8 = '0;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    s_valid_d = accept;
    s_first_d = s_first_q;
    s_last_d  = s_last_q;
    s_act_d   = s_act_q;
    s_wt_d    = s_wt_q;
    s_bias_d  = s_bias_q;
    p_valid_d = s_valid_q;
    p_first_d = p_first_q;
    p_last_d  = p_last_q;
    p_prod_d  = p_prod_q;
    p_bias_d  = p_bias_q;
    a_valid_d = p_valid_q;
    a_last_d  = a_last_q;
    acc_d     = acc_q;
    q_valid_d = a_valid_q & a_last_q;
    layer2_d  = layer2_q;

    // Operands are only captured on acceptance so unaccepted garbage never enters the pipe.
    if (accept) begin
      cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      s_act_d   = act;
      s_wt_d    = weight;
      s_first_d = (cnt_q == '0);
      s_last_d  = (cnt_q == CNT_LAST);
      if (cnt_q == '0) begin
        s_bias_d = bias;
      end
    end

    if (s_valid_q) begin
      p_prod_d  = 16'(s_act_q) * 16'(s_wt_q);
      p_first_d = s_first_q;
      p_last_d  = s_last_q;
      p_bias_d  = s_bias_q;
    end

    if (p_valid_q) begin
      acc_d    = p_first_q ? ACC_W'(p_bias_q) + ACC_W'(p_prod_q) : acc_q + ACC_W'(p_prod_q);
      a_last_d = p_last_q;
    end

    if (q_valid_d) begin
      layer2_d = sat8;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      s_valid_q <= 1'b0;
      s_first_q <= 1'b0;
      s_last_q  <= 1'b0;
      s_act_q   <= '0;
      s_wt_q    <= '0;
      s_bias_q  <= '0;
      p_valid_q <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_prod_q  <= '0;
      p_bias_q  <= '0;
      a_valid_q <= 1'b0;
      a_last_q  <= 1'b0;
      acc_q     <= '0;
      q_valid_q <= 1'b0;
      layer2_q  <= '0;
    end else if (enable) begin
      cnt_q     <= cnt_d;
      s_valid_q <= s_valid_d;
      s_first_q <= s_first_d;
      s_last_q  <= s_last_d;
      s_act_q   <= s_act_d;
      s_wt_q    <= s_wt_d;
      s_bias_q  <= s_bias_d;
      p_valid_q <= p_valid_d;
      p_first_q <= p_first_d;
      p_last_q  <= p_last_d;
      p_prod_q  <= p_prod_d;
      p_bias_q  <= p_bias_d;
      a_valid_q <= a_valid_d;
      a_last_q  <= a_last_d;
      acc_q     <= acc_d;
      q_valid_q <= q_valid_d;
      layer2_q  <= layer2_d;
    end
  end

  // Gating with enable presents each result to the pool stage exactly once across stalls.
  assign layer2    = layer2_q;
  assign out_valid = q_valid_q & enable;
  assign busy      = (cnt_q != '0) | s_valid_q | p_valid_q | a_valid_q | q_valid_q;

endmodule

// File: tb/tb_mac_window_unit.sv
// Scoreboard bench for mac_window_unit: ReLU and linear instances share stimulus;
// a negedge monitor pops expected results and checks value and enabled-cycle timing.
module tb_mac_window_unit;

  logic        clk = 1'b0;
  logic        rst, enable, in_valid;
  logic [7:0]  act, weight;
  logic [15:0] bias;
  logic [7:0]  l2_a, l2_b;
  logic        ov_a, ov_b, busy_a, busy_b;

  typedef struct {
    int l_relu;
    int l_lin;
    int ec;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ecyc     = 0;

  always #5 clk = ~clk;

  mac_window_unit #(.K(4), .ACC_W(24), .SHIFT(4), .RELU(1'b1)) dut_relu (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .act(act), .weight(weight),
    .bias(bias), .layer2(l2_a), .out_valid(ov_a), .busy(busy_a)
  );

  mac_window_unit #(.K(4), .ACC_W(24), .SHIFT(4), .RELU(1'b0)) dut_lin (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .act(act), .weight(weight),
    .bias(bias), .layer2(l2_b), .out_valid(ov_b), .busy(busy_b)
  );

  // Enabled-edge counter: the expected pulse position in this time base ignores stalls.
  always @(posedge clk) if (enable) ecyc <= ecyc + 1;

  task automatic chk(input string name, input int actual, input int expv);
    n_checks++;
    if (actual !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (ov_a || ov_b) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: got out_valid relu=%0d lin=%0d with no result pending",
                   ov_a, ov_b);
        end else begin
          e = sbq.pop_front();
          chk("pulse_ecyc", ecyc, e.ec);
          chk("layer2_relu", $signed(l2_a), e.l_relu);
          chk("layer2_lin", $signed(l2_b), e.l_lin);
          chk("ov_relu", int'(ov_a), 1);
          chk("ov_lin", int'(ov_b), 1);
        end
      end else if (sbq.size() > 0 && ecyc > sbq[0].ec) begin
        e = sbq.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missed_pulse: got none by enabled cycle %0d expected at %0d", ecyc, e.ec);
      end
    end
  end

  task automatic step(input bit iv, input bit en, input int a, input int w, input int b);
    in_valid = iv;
    enable   = en;
    act      = 8'(a);
    weight   = 8'(w);
    bias     = 16'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic win(input int a, input int w, input int b, input int e_relu, input int e_lin);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, a, w, b);
    sbq.push_back('{e_relu, e_lin, ecyc + 3});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by time %0t expected finish earlier", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; in_valid = 1'b0; act = '0; weight = '0; bias = '0;
    #12;
    chk("reset_layer2", int'(l2_a), 0);
    chk("reset_ov", int'(ov_a), 0);
    chk("reset_busy", int'(busy_a), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    win(16, 2, 0, 8, 8);                 idle(6);
    win(127, 127, 0, 127, 127);          idle(6);
    win(-128, 127, 0, 0, -128);          idle(6);
    win(-16, 2, 0, 0, -8);               idle(6);
    win(1, 1, 100, 7, 7);                idle(6);

    // Mixed signs; bias offered on later elements must be ignored.
    step(1'b1, 1'b1, 10, 7, 50);
    step(1'b1, 1'b1, -20, 3, -999);
    step(1'b1, 1'b1, 30, -2, 1234);
    step(1'b1, 1'b1, -5, 9, 0);
    sbq.push_back('{0, -3, ecyc + 3});
    idle(6);

    // Back-to-back windows.
    win(16, 2, 0, 8, 8);
    win(32, 2, 0, 16, 16);
    idle(3);
    chk("b2b_ov_second", int'(ov_a), 1);
    chk("b2b_busy_during", int'(busy_a), 1);
    chk("b2b_layer2", $signed(l2_a), 16);
    idle(1);
    chk("b2b_busy_after", int'(busy_a), 0);
    chk("b2b_ov_after", int'(ov_a), 0);
    idle(4);

    // Stalls mid-window (with in_valid high) and while the result sits in Q.
    step(1'b1, 1'b1, 3, 5, -20);
    step(1'b1, 1'b1, 3, 5, 0);
    step(1'b1, 1'b0, 127, 127, 0);
    step(1'b1, 1'b0, 127, 127, 0);
    step(1'b1, 1'b1, 3, 5, 0);
    step(1'b1, 1'b1, 3, 5, 0);
    sbq.push_back('{3, 3, ecyc + 3});
    idle(3);
    enable   = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("stall_q_ov", int'(ov_a), 0);
    chk("stall_q_layer2", $signed(l2_a), 3);
    chk("stall_q_busy", int'(busy_a), 1);
    @(posedge clk);
    #1;
    chk("stall_hold_layer2", $signed(l2_b), 3);
    chk("stall_hold_ov", int'(ov_b), 0);
    enable = 1'b1;
    #1;
    chk("stall_release_ov", int'(ov_a), 1);
    @(posedge clk);
    #1;
    chk("stall_once_ov", int'(ov_a), 0);
    chk("stall_busy_after", int'(busy_a), 0);
    idle(4);

    // Asynchronous reset between edges discards a partial window.
    step(1'b1, 1'b1, 100, 100, 0);
    step(1'b1, 1'b1, 100, 100, 0);
    chk("partial_busy", int'(busy_a), 1);
    chk("partial_layer2", $signed(l2_a), 3);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_layer2_relu", int'(l2_a), 0);
    chk("mid_rst_layer2_lin", int'(l2_b), 0);
    chk("mid_rst_ov", int'(ov_a), 0);
    chk("mid_rst_busy_relu", int'(busy_a), 0);
    chk("mid_rst_busy_lin", int'(busy_b), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    win(16, 2, 0, 8, 8);
    idle(6);

    for (int i = 0; i < 50 && sbq.size() > 0; i++) idle(1);
    if (sbq.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d results still pending expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mac_window_unit.md
Name: mac_window_unit

Overview:
Streaming multiply-accumulate stage directly upstream of the average-pool stage. It consumes one signed 8-bit activation/weight pair per accepted cycle and accumulates K products onto a per-window bias. It then requantizes (round, shift, saturate, optional ReLU) to the signed 8-bit value that the pool stage takes on its layer2 input. out_valid drives the pool stage's enable.

Parameters:
K, 4, products per output window (K >= 2)
ACC_W, 24, accumulator width in bits (>= 16 + clog2(K) + 1)
SHIFT, 4, requantization right-shift amount (0..ACC_W-8)
RELU, 1, 1 = clamp negative results to 0 after saturation; 0 = pass signed value

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
enable  input  1  global advance; 0 freezes every register in the block
in_valid  input  1  act/weight/bias valid this cycle
act  input  8  signed activation
weight  input  8  signed weight
bias  input  16  signed bias; sampled only with element 0 of a window
layer2  output  8  signed requantized result
out_valid  output  1  layer2 valid; single-cycle pulse per window
busy  output  1  window partially accumulated or result in flight

Behaviour:
- Accept: element accepted on a clk edge iff in_valid=1 and enable=1. When enable=0, in_valid is ignored.
- Element counter 0..K-1 advances per accepted element. It wraps to 0 after K-1. The element with counter 0 also samples bias.
- Pipeline with three registered stages, each advancing only when enable=1:
  - P (multiply): 16-bit signed product, first/last tags, bias.
  - A (accumulate): acc <= sext(bias) + product on first; acc <= acc + product otherwise. Last tag is forwarded.
  - Q (output): requantize acc on last; load layer2; set internal valid flag.
- Requantize:
  - r = acc + (1 << (SHIFT-1)) when SHIFT > 0, else r = acc.
  - Arithmetic right-shift by SHIFT (floor).
  - Saturate to [-128, 127].
  - If RELU = 1, negative results become 0.
- Accumulator overflow wraps modulo 2^ACC_W. This does not occur for legal parameters.
- Latency:
  - Element K-1 is accepted at edge t.
  - Q loads at edge t+3. out_valid is high in the cycle after that edge, with no stalls.
  - Each stall cycle (enable=0) adds exactly one cycle. Values are unaffected.
- out_valid port = internal valid flag AND enable. A result is therefore presented to the pool stage exactly once, even across stalls.
  - Internal flag clears on the next enabled edge unless a new last element reaches Q.
- layer2 holds its last value between results.
- Back-to-back windows: element 0 of window n+1 may be accepted on the edge after element K-1 of window n. No bubble. Consecutive out_valid pulses are K enabled cycles apart.
- busy = (counter != 0) OR any P/A stage valid OR internal Q flag.
- Reset (async, any time, including mid-window):
  - counter = 0; all stage valids = 0; acc = 0; layer2 = 0; out_valid = 0; busy = 0.
  - Partial window discarded. The first accepted element after reset is element 0.
- in_valid with X on act/weight while not accepted must not corrupt state.

Test Plan:
- K=4, SHIFT=4, RELU=1, bias=0. act=16, weight=2 on 4 consecutive cycles -> sum 128, (128+8)>>4 = 8. layer2=8, out_valid single pulse 3 cycles after last accept.
- Saturation: act=127, weight=127 x4, bias=0 -> acc 64516, shifted 4032 -> layer2=127. act=-128, weight=127 x4 with RELU=0 -> layer2=-128.
- Sign/ReLU: act=-16, weight=2 x4, bias=0 -> (-128+8)>>4 = -8. RELU=1 gives 0; RELU=0 gives -8 (0xF8). Bias: bias=100, act=1, weight=1 x4 -> (104+8)>>4 = 7.
- Back-to-back: 8 consecutive elements (window A all 16*2, window B all 32*2) -> out_valid pulses exactly 4 cycles apart. layer2=8 then 16. busy deasserts one cycle after the second pulse.
- Stall: enable=0 for 2 cycles after element 1 and again while result is in Q -> layer2 value unchanged. out_valid delayed by the total stall count and seen only while enable=1, asserted for exactly one enabled cycle. in_valid during stall not counted.
- Reset mid-window: 2 elements accepted, rst pulsed asynchronously between edges -> layer2=0, out_valid=0, busy=0 immediately. The next 4 elements (act=16, weight=2) produce layer2=8 with no contribution from discarded data.
